// File: rtl/vga_timing_pkg.sv
// Shared timing types and the 640x480@60 default mode for the VGA timing engine.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam vga_timing_t VGA_480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

  localparam int DEF_CW      = 10;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_FRAME_W = 8;

  function automatic int timing_total(vga_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// Bundle of run controls and video timing outputs around one vga_timing_engine.
// Controls (en, stop) are level inputs sampled on clk; there is no handshake,
// every output is a registered level or single-clk strobe.
interface vga_timing_engine_if #(
  parameter int CW      = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic               stop;
  logic               pix_tick;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               blank_n;
  logic               sync_n;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic               sof;
  logic               eol;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en, stop,
    output pix_tick, hsync, vsync, de, blank_n, sync_n, x, y, sof, eol, frame_cnt
  );

  modport slave (
    output en, stop,
    input  pix_tick, hsync, vsync, de, blank_n, sync_n, x, y, sof, eol, frame_cnt
  );
endinterface

// File: rtl/pixel_div.sv
// Pixel-rate divider: tick is high for one clk every CLK_DIV enabled clks.
module pixel_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Internal only; the engine registers it before it leaves the block.
  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster timing: pixel/line counters, sync/blank decode and frame strobes.
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640_H.active),
  parameter int H_FP     = int'(VGA_640_H.fp),
  parameter int H_SYNC   = int'(VGA_640_H.sync),
  parameter int H_BP     = int'(VGA_640_H.bp),
  parameter int V_ACTIVE = int'(VGA_480_V.active),
  parameter int V_FP     = int'(VGA_480_V.fp),
  parameter int V_SYNC   = int'(VGA_480_V.sync),
  parameter int V_BP     = int'(VGA_480_V.bp),
  parameter int CW       = DEF_CW,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FRAME_W  = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               stop,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               blank_n,
  output logic               sync_n,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam vga_timing_t H_CFG = '{16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC), 16'(H_BP)};
  localparam vga_timing_t V_CFG = '{16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC), 16'(V_BP)};
  localparam int H_TOTAL = timing_total(H_CFG);
  localparam int V_TOTAL = timing_total(V_CFG);

  if (CLK_DIV < 1 ||
      longint'(H_TOTAL - 1) > (longint'(1) << CW) - 1 ||
      longint'(V_TOTAL - 1) > (longint'(1) << CW) - 1) begin : g_cfg_err
    $error("vga_timing_engine: CLK_DIV < 1 or raster does not fit in CW bits");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_EOL  = CW'(H_ACTIVE - 1);
  // Window bounds can reach 2^CW, so they carry one extra bit.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYN_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYN_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYN_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYN_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic          tick;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          h_end, v_end;
  logic          active, hs_win, vs_win, at_org, at_eol;
  logic          at_org_q, at_eol_q;

  pixel_div #(.CLK_DIV(CLK_DIV)) u_pixel_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign h_end = (hc == H_LAST);
  assign v_end = (vc == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (tick) begin
      hc <= h_end ? '0 : hc + 1'b1;
      if (h_end) begin
        vc <= v_end ? '0 : vc + 1'b1;
        if (v_end && !stop) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    active = ({1'b0, hc} < H_ACT_END) && ({1'b0, vc} < V_ACT_END);
    hs_win = ({1'b0, hc} >= H_SYN_BEG) && ({1'b0, hc} < H_SYN_END);
    vs_win = ({1'b0, vc} >= V_SYN_BEG) && ({1'b0, vc} < V_SYN_END);
    at_org = (hc == '0) && (vc == '0);
    at_eol = (hc == H_EOL) && ({1'b0, vc} < V_ACT_END);
  end

  // at_*_q remember the previous registered position so sof/eol fire only on
  // entry, even when CLK_DIV>1 or en=0 holds the position for several clks.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tick <= 1'b0;
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      de       <= 1'b0;
      blank_n  <= 1'b0;
      x        <= '0;
      y        <= '0;
      sof      <= 1'b0;
      eol      <= 1'b0;
      at_org_q <= 1'b0;
      at_eol_q <= 1'b0;
    end else begin
      pix_tick <= tick;
      hsync    <= hs_win ? HS_POL : ~HS_POL;
      vsync    <= vs_win ? VS_POL : ~VS_POL;
      de       <= active;
      blank_n  <= active;
      x        <= hc;
      y        <= vc;
      sof      <= at_org && !at_org_q;
      eol      <= at_eol && !at_eol_q;
      at_org_q <= at_org;
      at_eol_q <= at_eol;
    end
  end

  assign sync_n = 1'b1;
endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a 14x7 raster: one DUT at CLK_DIV=1/active-low
// syncs, one at CLK_DIV=3/active-high syncs, both sharing the run controls.
module tb_vga_timing_engine;
  localparam int CW = 10;
  localparam int FW = 8;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  typedef struct packed {
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          blank_n;
    logic          sync_n;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic [FW-1:0] frame;
  } obs_t;
  localparam int W = $bits(obs_t);

  typedef struct {
    bit rst;
    bit en;
    bit stop;
    int cycles;
    int exp_x;
    int exp_y;
    int exp_frame;
    bit exp_pix;
  } vec_t;

  logic clk;
  logic rst;
  vga_timing_engine_if #(.CW(CW), .FRAME_W(FW)) vif ();

  logic          pix_tick1, hsync1, vsync1, de1, blank_n1, sync_n1, sof1, eol1;
  logic [CW-1:0] x1, y1;
  logic [FW-1:0] frame_cnt1;

  obs_t act0, act1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_ticks[2];
  int m_div[2];
  int m_frame[2];
  bit m_org[2];
  bit m_eol[2];

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(CW), .CLK_DIV(DIV0), .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(FW)
  ) dut0 (
    .clk(clk), .rst(rst), .en(vif.en), .stop(vif.stop),
    .pix_tick(vif.pix_tick), .hsync(vif.hsync), .vsync(vif.vsync), .de(vif.de),
    .blank_n(vif.blank_n), .sync_n(vif.sync_n), .x(vif.x), .y(vif.y),
    .sof(vif.sof), .eol(vif.eol), .frame_cnt(vif.frame_cnt)
  );

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(CW), .CLK_DIV(DIV1), .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(FW)
  ) dut1 (
    .clk(clk), .rst(rst), .en(vif.en), .stop(vif.stop),
    .pix_tick(pix_tick1), .hsync(hsync1), .vsync(vsync1), .de(de1),
    .blank_n(blank_n1), .sync_n(sync_n1), .x(x1), .y(y1),
    .sof(sof1), .eol(eol1), .frame_cnt(frame_cnt1)
  );

  assign act0 = {vif.pix_tick, vif.hsync, vif.vsync, vif.de, vif.blank_n, vif.sync_n,
                 vif.x, vif.y, vif.sof, vif.eol, vif.frame_cnt};
  assign act1 = {pix_tick1, hsync1, vsync1, de1, blank_n1, sync_n1,
                 x1, y1, sof1, eol1, frame_cnt1};

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: position is derived from the count of pixel ticks since reset.
  task automatic model_step(input int d, input bit r, input bit e, input bit s);
    obs_t o;
    int   hc, vc, div;
    bit   pol, tk, org, eolp;
    div = (d == 0) ? DIV0 : DIV1;
    pol = (d == 1);
    o = '0;
    o.sync_n = 1'b1;
    if (r) begin
      m_ticks[d] = 0; m_div[d] = 0; m_frame[d] = 0; m_org[d] = 0; m_eol[d] = 0;
      o.hsync = ~pol;
      o.vsync = ~pol;
    end else begin
      hc   = m_ticks[d] % HT;
      vc   = m_ticks[d] / HT;
      tk   = e && (m_div[d] == div - 1);
      org  = (hc == 0) && (vc == 0);
      eolp = (hc == 7) && (vc < 4);
      o.pix_tick = tk;
      o.de       = (hc < 8) && (vc < 4);
      o.blank_n  = o.de;
      o.hsync    = (hc >= 10 && hc < 12) ? pol : ~pol;
      o.vsync    = (vc == 5) ? pol : ~pol;
      o.x        = CW'(hc);
      o.y        = CW'(vc);
      o.sof      = org && !m_org[d];
      o.eol      = eolp && !m_eol[d];
      m_org[d]   = org;
      m_eol[d]   = eolp;
      if (e) m_div[d] = (m_div[d] + 1) % div;
      if (tk) begin
        if (m_ticks[d] == HT*VT - 1 && !s) m_frame[d] = (m_frame[d] + 1) % 256;
        m_ticks[d] = (m_ticks[d] + 1) % (HT*VT);
      end
      o.frame = FW'(m_frame[d]);
    end
    if (d == 0) exp_q0.push_back(o);
    else        exp_q1.push_back(o);
  endtask

  task automatic sb_compare(input string name, input logic [W-1:0] got, input bit empty,
                            input logic [W-1:0] exp);
    checks++;
    if (empty || got !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s cyc=%0d: got %h expected %h (queue_empty=%0d)", name, cyc, got, exp, empty);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // driver: one clk with the given controls, then scoreboard both DUTs
  task automatic cycle(input bit r, input bit e, input bit s);
    logic [W-1:0] exp;
    bit           empty;
    rst = r;
    vif.en = e;
    vif.stop = s;
    model_step(0, r, e, s);
    model_step(1, r, e, s);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    empty = (exp_q0.size() == 0);
    exp = empty ? '0 : exp_q0.pop_front();
    sb_compare("dut0_outputs", act0, empty, exp);
    empty = (exp_q1.size() == 0);
    exp = empty ? '0 : exp_q1.pop_front();
    sb_compare("dut1_outputs", act1, empty, exp);
  endtask

  vec_t tbl[14];
  int   sof_cyc[$];
  int   hs1_cnt, vs1_cnt, eol0_cnt, de0_cnt;

  initial begin
    rst = 1'b1;
    vif.en = 1'b0;
    vif.stop = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_ticks[d] = 0; m_div[d] = 0; m_frame[d] = 0; m_org[d] = 0; m_eol[d] = 0;
    end

    //          rst en stop cycles  x   y  frame pix
    tbl[0]  = '{1, 1, 0,     3,      0,  0,   0,  0};
    tbl[1]  = '{0, 1, 0,     1,      0,  0,   0,  1};
    tbl[2]  = '{0, 1, 0,     2,      2,  0,   0,  1};
    tbl[3]  = '{0, 0, 0,     5,      3,  0,   0,  0};
    tbl[4]  = '{0, 1, 0,     2,      4,  0,   0,  1};
    tbl[5]  = '{0, 1, 0,    23,     13,  1,   0,  1};
    tbl[6]  = '{0, 1, 0,    10,      9,  2,   0,  1};
    tbl[7]  = '{1, 1, 0,     1,      0,  0,   0,  0};
    tbl[8]  = '{0, 1, 0,     1,      0,  0,   0,  1};
    tbl[9]  = '{0, 1, 0,    97,     13,  6,   1,  1};
    tbl[10] = '{0, 1, 0,     1,      0,  0,   1,  1};
    tbl[11] = '{0, 1, 0, 24891,     13,  6, 255,  1};
    tbl[12] = '{0, 1, 1,    98,     13,  6, 255,  1};
    tbl[13] = '{0, 1, 0,    98,     13,  6,   0,  1};

    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) cycle(tbl[i].rst, tbl[i].en, tbl[i].stop);
      check($sformatf("vec%0d_x", i),     int'(vif.x),         tbl[i].exp_x);
      check($sformatf("vec%0d_y", i),     int'(vif.y),         tbl[i].exp_y);
      check($sformatf("vec%0d_frame", i), int'(vif.frame_cnt), tbl[i].exp_frame);
      check($sformatf("vec%0d_pix", i),   int'(vif.pix_tick),  int'(tbl[i].exp_pix));
    end

    // Active-high syncs must idle low in reset.
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    check("pol1_reset_hsync", int'(hsync1), 0);
    check("pol1_reset_vsync", int'(vsync1), 0);

    // One DUT1 frame (98 px * 3 clk) = three DUT0 frames.
    hs1_cnt = 0; vs1_cnt = 0; eol0_cnt = 0; de0_cnt = 0;
    for (int k = 1; k <= 294; k++) begin
      cycle(0, 1, 0);
      if (vif.sof) sof_cyc.push_back(k);
      hs1_cnt  += int'(hsync1);
      vs1_cnt  += int'(vsync1);
      eol0_cnt += int'(vif.eol);
      de0_cnt  += int'(vif.de);
    end
    check("sof_count", sof_cyc.size(), 3);
    for (int i = 1; i < sof_cyc.size(); i++)
      check($sformatf("sof_interval%0d", i), sof_cyc[i] - sof_cyc[i-1], 98);
    check("sof_first_after_release", (sof_cyc.size() > 0) ? sof_cyc[0] : -1, 1);
    check("pol1_hsync_high_clks", hs1_cnt, 42);
    check("pol1_vsync_high_clks", vs1_cnt, 42);
    check("eol_count", eol0_cnt, 12);
    check("de_count", de0_cnt, 96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync in lines.
REQ-005 SHALL have parameter CW, default 10, coordinate width.
REQ-006 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (>=1).
REQ-007 SHALL have parameters HS_POL, VS_POL, default 0, sync active level (0 = active-low).
REQ-008 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-009 SHALL have ports, in order: clk in 1 system clock; rst in 1 synchronous active-high reset; en in 1 run enable; stop in 1 freeze frame counter; pix_tick out 1 pixel strobe; hsync out 1; vsync out 1; de out 1 active-video; blank_n out 1 DAC blank (high = visible); sync_n out 1 constant 1; x out CW; y out CW; sof out 1 start-of-frame; eol out 1 end-of-line; frame_cnt out FRAME_W.
REQ-010 SHALL have one clock domain, clk; rst is synchronous and active-high.

Function
REQ-011 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or CLK_DIV<1.
REQ-012 SHALL keep a divider counter 0..CLK_DIV-1 advancing each clk while en=1; pix_tick SHALL be 1 for exactly one clk when divider = CLK_DIV-1 and en=1; CLK_DIV=1 gives pix_tick = en.
REQ-013 SHALL hold divider, hc, vc unchanged while en=0; pix_tick=0.
REQ-014 On pix_tick, hc SHALL increment, wrapping H_TOTAL-1 -> 0 (never reaching H_TOTAL).
REQ-015 On pix_tick with hc=H_TOTAL-1, vc SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-016 On the frame wrap (hc=H_TOTAL-1, vc=V_TOTAL-1, pix_tick) frame_cnt SHALL increment modulo 2^FRAME_W unless stop=1, in which case it holds.
REQ-017 All outputs except sync_n SHALL be registered, reflecting hc/vc one clk after they change.
REQ-018 de SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE (strict); blank_n = de.
REQ-019 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vsync same with V terms and VS_POL.
REQ-020 x,y SHALL equal hc,vc (unclamped, including blanking region).
REQ-021 sof SHALL pulse one clk when the registered position first becomes (0,0); eol SHALL pulse one clk when it first becomes hc=H_ACTIVE-1 on an active line.

Reset
REQ-022 While rst=1 at a clk edge: divider, hc, vc, frame_cnt := 0; x,y := 0; de, blank_n, sof, eol, pix_tick := 0; hsync := ~HS_POL; vsync := ~VS_POL.
REQ-023 rst SHALL override en and stop; rst mid-frame SHALL restart at (0,0) with no sof emitted during reset.
REQ-024 First clk after reset release with en=1 SHALL present position (0,0): de=1, sof=1.

Structure
REQ-025 Package vga_timing_pkg SHALL hold the 640x480@60 default constants and a packed typedef vga_timing_t (active, fp, sync, bp) for H and V.
REQ-026 Divider SHALL be sub-module pixel_div (params CLK_DIV; ports clk, rst, en, tick).
REQ-027 Implementation SHALL use no combinational path from inputs to outputs except sync_n.

Verification
REQ-028 Defaults, CLK_DIV=2, en=1, one frame -> 840000 clk per frame, hsync low for 192 clk per line, vsync low for 2 lines, de high count 307200 pixel ticks.
REQ-029 H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, CLK_DIV=1 -> hc sequence 0..13 then 0; y wraps 6 -> 0; sof every 98 clk.
REQ-030 Small config, frame_cnt=255, FRAME_W=8, frame wrap -> frame_cnt=0; repeat with stop=1 -> frame_cnt holds.
REQ-031 en=0 for 5 clk at hc=3 -> x stays 3, pix_tick=0, then resumes at 4.
REQ-032 rst asserted at hc=10, vc=2 -> next clk all outputs per REQ-022; release -> sof=1, x=y=0 next clk.
REQ-033 HS_POL=1, VS_POL=1 -> hsync/vsync high only within sync windows, low at reset.
